// File: rtl/wb_gpio_irq_pkg.sv
// Shared constants, bus request payload and helpers for the wb_gpio_irq slave.
package wb_gpio_irq_pkg;

  localparam int unsigned NGPIO_MAX = 32;
  localparam int unsigned WB_AW     = 32;
  localparam int unsigned WB_DW     = 32;
  localparam int unsigned REG_IDX_W = 4;

  // Word indices (byte offset / 4) of the register map
  localparam logic [REG_IDX_W-1:0] REG_IN     = 4'h0;
  localparam logic [REG_IDX_W-1:0] REG_OUT    = 4'h1;
  localparam logic [REG_IDX_W-1:0] REG_DIR    = 4'h2;
  localparam logic [REG_IDX_W-1:0] REG_IE     = 4'h3;
  localparam logic [REG_IDX_W-1:0] REG_EDGE   = 4'h4;
  localparam logic [REG_IDX_W-1:0] REG_STAT   = 4'h5;
  localparam logic [REG_IDX_W-1:0] REG_OUTSET = 4'h6;
  localparam logic [REG_IDX_W-1:0] REG_OUTCLR = 4'h7;
  localparam logic [REG_IDX_W-1:0] REG_BOTH   = 4'h8;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic                 we;
    logic [WB_DW-1:0]     wdata;
    logic [WB_DW-1:0]     wmask;
  } wb_req_t;

  // Expand byte-lane enables to a bit mask
  function automatic logic [WB_DW-1:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// Wishbone B3 classic bus bundle between the interconnect and the GPIO slave.
interface wb_gpio_irq_if;
  import wb_gpio_irq_pkg::*;

  logic [WB_AW-1:0] wb_adr_i;
  logic [WB_DW-1:0] wb_dat_i;
  logic [3:0]       wb_sel_i;
  logic             wb_we_i;
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic [2:0]       wb_cti_i;
  logic [1:0]       wb_bte_i;
  logic [WB_DW-1:0] wb_dat_o;
  logic             wb_ack_o;
  logic             wb_err_o;
  logic             wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

endinterface

// File: rtl/wb_gpio_irq_sync_edge.sv
// gpio_sync_edge: multi-flop input synchroniser plus history flop; flags
// rising and falling transitions of the synchronised pins.
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise_c,
  output logic [WIDTH-1:0] fall_c
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] edge_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
      hist_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
      hist_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync   = stage_q[SYNC_STAGES-1];
  assign edge_c = sync ^ hist_q;
  assign rise_c = edge_c & sync;
  assign fall_c = edge_c & ~sync;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone B3 GPIO slave with per-pin edge interrupt, 1..32 pins.
// Define WB_GPIO_IRQ_BOTH_EDGE_EN to add the BOTH (any-edge) register at 0x20.
module wb_gpio_irq
  import wb_gpio_irq_pkg::*;
#(
  parameter int unsigned NGPIO       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_gpio_irq_if.slave     wb,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_dir_o,
  output logic             irq_o
);

  wb_req_t          req_c;
  logic             acc_c;
  logic             wr_c;
  logic             ack_q;
  logic [WB_DW-1:0] dat_q;
  logic [WB_DW-1:0] rdata_c;
  logic [NGPIO-1:0] wdat_c;
  logic [NGPIO-1:0] wmask_c;
  logic [NGPIO-1:0] in_sync;
  logic [NGPIO-1:0] rise_c;
  logic [NGPIO-1:0] fall_c;
  logic [NGPIO-1:0] hit_c;
  logic [NGPIO-1:0] clr_c;
  logic [NGPIO-1:0] ie_q;
  logic [NGPIO-1:0] edge_q;
  logic [NGPIO-1:0] stat_q;
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
  logic [NGPIO-1:0] both_q;
`endif
  logic             unused_c;

  gpio_sync_edge #(
    .WIDTH       (NGPIO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .din    (gpio_i),
    .sync   (in_sync),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_comb begin
    req_c.idx   = wb.wb_adr_i[5:2];
    req_c.we    = wb.wb_we_i;
    req_c.wdata = wb.wb_dat_i;
    req_c.wmask = lane_mask(wb.wb_sel_i);
  end

  // One wait state: a new access starts only while no ack is being driven
  assign acc_c   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_c    = acc_c & req_c.we;
  assign wdat_c  = req_c.wdata[NGPIO-1:0];
  assign wmask_c = req_c.wmask[NGPIO-1:0];
  assign clr_c   = (wr_c && req_c.idx == REG_STAT) ? (wdat_c & wmask_c) : '0;

  always_comb begin
    hit_c = (edge_q & rise_c) | (~edge_q & fall_c);
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
    hit_c = (both_q & (rise_c | fall_c)) | (~both_q & hit_c);
`endif
  end

  always_comb begin
    rdata_c = '0;
    case (req_c.idx)
      REG_IN:   rdata_c = WB_DW'(in_sync);
      REG_OUT:  rdata_c = WB_DW'(gpio_o);
      REG_DIR:  rdata_c = WB_DW'(gpio_dir_o);
      REG_IE:   rdata_c = WB_DW'(ie_q);
      REG_EDGE: rdata_c = WB_DW'(edge_q);
      REG_STAT: rdata_c = WB_DW'(stat_q);
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
      REG_BOTH: rdata_c = WB_DW'(both_q);
`endif
      default:  rdata_c = '0;
    endcase
  end

  function automatic logic [NGPIO-1:0] merge(input logic [NGPIO-1:0] old_v,
                                             input logic [NGPIO-1:0] new_v,
                                             input logic [NGPIO-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      gpio_o     <= '0;
      gpio_dir_o <= '0;
      ie_q       <= '0;
      edge_q     <= '0;
      stat_q     <= '0;
      irq_o      <= 1'b0;
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
      both_q     <= '0;
`endif
    end else begin
      ack_q  <= acc_c;
      if (acc_c && !req_c.we) dat_q <= rdata_c;
      // New hits win over a same-cycle W1C
      stat_q <= (stat_q & ~clr_c) | hit_c;
      irq_o  <= |(stat_q & ie_q);
      if (wr_c) begin
        case (req_c.idx)
          REG_OUT:    gpio_o     <= merge(gpio_o, wdat_c, wmask_c);
          REG_DIR:    gpio_dir_o <= merge(gpio_dir_o, wdat_c, wmask_c);
          REG_IE:     ie_q       <= merge(ie_q, wdat_c, wmask_c);
          REG_EDGE:   edge_q     <= merge(edge_q, wdat_c, wmask_c);
          REG_OUTSET: gpio_o     <= gpio_o | (wdat_c & wmask_c);
          REG_OUTCLR: gpio_o     <= gpio_o & ~(wdat_c & wmask_c);
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
          REG_BOTH:   both_q     <= merge(both_q, wdat_c, wmask_c);
`endif
          default: ;
        endcase
      end
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;

  assign unused_c = ^{wb.wb_cti_i, wb.wb_bte_i, wb.wb_adr_i[31:6], wb.wb_adr_i[1:0], req_c};

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Testbench for wb_gpio_irq (NGPIO=8, SYNC_STAGES=2): per-cycle reference
// model plus directed accesses with hand-computed expectations.
module tb_wb_gpio_irq;
  import wb_gpio_irq_pkg::*;

  localparam int NG = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NG-1:0] gpio_i = '0;
  logic [NG-1:0] gpio_o;
  logic [NG-1:0] gpio_dir;
  logic          irq;

  wb_gpio_irq_if wb ();

  wb_gpio_irq #(.NGPIO(NG), .SYNC_STAGES(SS)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .wb         (wb),
    .gpio_i     (gpio_i),
    .gpio_o     (gpio_o),
    .gpio_dir_o (gpio_dir),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pin value delayed through the sampling pipeline,
  // registers as plain bytes (only byte lane 0 matters for 8 pins).
  logic [NG-1:0] m_pin [0:SS];
  logic [NG-1:0] m_out, m_dir, m_ie, m_edge, m_stat, m_both;
  logic          m_irq, m_ack, m_rdv;
  logic [31:0]   m_rd;
  logic [NG-1:0] m_in, m_prev, m_rise, m_fall, m_hit, m_wd, m_clr;
  logic          m_acc, m_wr;
  logic [3:0]    m_idx;
  logic [31:0]   m_rdata;

  assign m_in   = m_pin[SS-1];
  assign m_prev = m_pin[SS];
  assign m_rise = m_in & ~m_prev;
  assign m_fall = ~m_in & m_prev;
  assign m_acc  = wb.wb_cyc_i & wb.wb_stb_i & ~m_ack;
  assign m_wr   = m_acc & wb.wb_we_i;
  assign m_idx  = wb.wb_adr_i[5:2];
  assign m_wd   = wb.wb_sel_i[0] ? wb.wb_dat_i[7:0] : 8'h00;
  assign m_clr  = (m_wr && m_idx == 4'd5) ? m_wd : 8'h00;

  always_comb begin
    m_hit = 8'h00;
    for (int i = 0; i < NG; i++) begin
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
      if (m_both[i]) m_hit[i] = m_rise[i] | m_fall[i];
      else
`endif
      m_hit[i] = m_edge[i] ? m_rise[i] : m_fall[i];
    end
  end

  always_comb begin
    case (m_idx)
      4'd0:    m_rdata = {24'h0, m_in};
      4'd1:    m_rdata = {24'h0, m_out};
      4'd2:    m_rdata = {24'h0, m_dir};
      4'd3:    m_rdata = {24'h0, m_ie};
      4'd4:    m_rdata = {24'h0, m_edge};
      4'd5:    m_rdata = {24'h0, m_stat};
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
      4'd8:    m_rdata = {24'h0, m_both};
`endif
      default: m_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= SS; i++) m_pin[i] <= '0;
      m_out <= '0; m_dir <= '0; m_ie <= '0; m_edge <= '0; m_stat <= '0; m_both <= '0;
      m_irq <= 1'b0; m_ack <= 1'b0; m_rdv <= 1'b0; m_rd <= '0;
    end else begin
      m_pin[0] <= gpio_i;
      for (int i = 1; i <= SS; i++) m_pin[i] <= m_pin[i-1];
      m_ack  <= m_acc;
      m_rdv  <= m_acc & ~wb.wb_we_i;
      if (m_acc && !wb.wb_we_i) m_rd <= m_rdata;
      m_stat <= (m_stat & ~m_clr) | m_hit;
      m_irq  <= |(m_stat & m_ie);
      if (m_wr && wb.wb_sel_i[0]) begin
        case (m_idx)
          4'd1: m_out  <= wb.wb_dat_i[7:0];
          4'd2: m_dir  <= wb.wb_dat_i[7:0];
          4'd3: m_ie   <= wb.wb_dat_i[7:0];
          4'd4: m_edge <= wb.wb_dat_i[7:0];
          4'd6: m_out  <= m_out | wb.wb_dat_i[7:0];
          4'd7: m_out  <= m_out & ~wb.wb_dat_i[7:0];
`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
          4'd8: m_both <= wb.wb_dat_i[7:0];
`endif
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(wb.wb_ack_o), 32'(m_ack));
      chk("gpio_o", 32'(gpio_o), 32'(m_out));
      chk("gpio_dir_o", 32'(gpio_dir), 32'(m_dir));
      chk("irq_o", 32'(irq), 32'(m_irq));
      if (m_ack && m_rdv) chk("rdata_model", wb.wb_dat_o, m_rd);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at #1 after an edge; returns one idle cycle after the ack
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd);
    int n = 0;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_dat_i = dat;  wb.wb_sel_i = sel;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb.wb_ack_o && n < 8);
    chk("ack_latency", 32'(n), 32'd1);
    rd = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    tick(1);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    bus(1'b1, adr, dat, sel, d);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, adr, 32'h0, 4'hF, d);
    chk(nm, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0; wb.wb_we_i = 1'b0;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_cti_i = '0; wb.wb_bte_i = '0;

    tick(2);
    chk("rst_ack", 32'(wb.wb_ack_o), 32'd0);
    chk("rst_dat", wb.wb_dat_o, 32'd0);
    chk("rst_gpio_o", 32'(gpio_o), 32'd0);
    chk("rst_dir", 32'(gpio_dir), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("err_tied", 32'({wb.wb_err_o, wb.wb_rty_o}), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(1);

    for (int a = 0; a < 9; a++) rdchk("rst_read", 32'(a * 4), 32'h0);

    // Reset arriving with a write in flight: no ack, write dropped
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 32'h04; wb.wb_dat_i = 32'h55; wb.wb_sel_i = 4'hF;
    rst_n = 1'b0;
    tick(1);
    chk("midrst_ack", 32'(wb.wb_ack_o), 32'd0);
    rst_n = 1'b1;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    tick(1);
    chk("midrst_out", 32'(gpio_o), 32'd0);

    wr(32'h04, 32'hA5, 4'hF);
    rdchk("out_rw", 32'h04, 32'h0000_00A5);
    wr(32'h08, 32'hFFFF_FF3C, 4'b0001);
    rdchk("dir_sel", 32'h08, 32'h0000_003C);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    rdchk("out_width", 32'h04, 32'h0000_00FF);
    wr(32'h04, 32'h0000_1200, 4'b0010);
    rdchk("out_lane1_only", 32'h04, 32'h0000_00FF);
    wr(32'h24, 32'hFFFF_FFFF, 4'hF);
    rdchk("unmapped", 32'h24, 32'h0);

    wr(32'h04, 32'h0F, 4'hF);
    wr(32'h18, 32'hF0, 4'hF);
    wr(32'h1C, 32'h03, 4'hF);
    chk("outset_clr", 32'(gpio_o), 32'h0000_00FC);

    // Rising-edge interrupt on pin 0
    wr(32'h0C, 32'h01, 4'hF);
    wr(32'h10, 32'h01, 4'hF);
    gpio_i[0] = 1'b1;
    tick(1); chk("irq_e1", 32'(irq), 32'd0);
    tick(1); chk("irq_e2", 32'(irq), 32'd0);
    tick(1); chk("irq_e3", 32'(irq), 32'd0);
    tick(1); chk("irq_e4", 32'(irq), 32'd1);
    rdchk("stat_rise", 32'h14, 32'h01);
    rdchk("in_read", 32'h00, 32'h01);
    wr(32'h14, 32'h01, 4'hF);
    chk("irq_cleared", 32'(irq), 32'd0);

    gpio_i[0] = 1'b0;
    tick(5);
    rdchk("stat_fall_none", 32'h14, 32'h00);
    chk("irq_fall_none", 32'(irq), 32'd0);

    // W1C landing on the same edge as a fresh rise: the bit stays set
    gpio_i[0] = 1'b1;
    tick(5);
    chk("irq_pre_collide", 32'(irq), 32'd1);
    gpio_i[0] = 1'b0;
    tick(5);
    gpio_i[0] = 1'b1;
    tick(2);
    wr(32'h14, 32'h01, 4'hF);
    chk("irq_collide", 32'(irq), 32'd1);
    rdchk("stat_collide", 32'h14, 32'h01);
    wr(32'h14, 32'h01, 4'hF);
    rdchk("stat_after_clr", 32'h14, 32'h00);

`ifdef WB_GPIO_IRQ_BOTH_EDGE_EN
    wr(32'h20, 32'h02, 4'hF);
    wr(32'h0C, 32'h02, 4'hF);
    gpio_i[1] = 1'b1;
    tick(5);
    rdchk("both_rise", 32'h14, 32'h02);
    chk("both_irq", 32'(irq), 32'd1);
    wr(32'h14, 32'h02, 4'hF);
    gpio_i[1] = 1'b0;
    tick(5);
    rdchk("both_fall", 32'h14, 32'h02);
    rdchk("both_reg", 32'h20, 32'h02);
`else
    wr(32'h20, 32'hFF, 4'hF);
    rdchk("both_absent", 32'h20, 32'h00);
    gpio_i[1] = 1'b1;
    tick(5);
    rdchk("pin1_rise_falling_mode", 32'h14, 32'h00);
`endif

    tick(2);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
